// File: rtl/mul_sign_ctrl_pkg.sv
// Shared types and helpers for the RV32M multiply sign-control wrapper.
// The MUL_ZERO_SHORTCUT_EN option is handled in mul_sign_ctrl.sv.
package mul_sign_ctrl_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    FIXUP,
    RESP
  } mul_state_e;

  localparam int unsigned MAX_WAIT_DEFAULT = 40;

  function automatic logic op_a_signed(input mul_op_e op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(input mul_op_e op);
    return op == MUL_OP_MULH;
  endfunction

  // Two's-complement magnitude; 0x80000000 maps to itself, which is right as unsigned.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Combinational 64-bit conditional negate followed by upper/lower word select.
// Shared with the divider wrapper.
module mul_sign_fix (
  input  logic [63:0] prod,
  input  logic        neg,
  input  logic        hi_sel,
  output logic [31:0] word
);

  logic [63:0] fixed;

  always_comb begin
    fixed = neg ? (~prod + 64'd1) : prod;
    word  = hi_sel ? fixed[63:32] : fixed[31:0];
  end

endmodule

// File: rtl/mul_sign_ctrl.sv
// RV32M multiply front/back stage around an unsigned shift-add core.
// Define MUL_ZERO_SHORTCUT_EN to answer zero-operand requests without the core.
module mul_sign_ctrl
  import mul_sign_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_init,
  input  logic        mul_ready,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo
);

  mul_state_e  state_q, state_d;
  mul_op_e     op_q, op_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] data_q, data_d;
  logic [31:0] fix_word;
  mul_op_e     req_op_e;
  logic        a_sgn, b_sgn;

  assign req_op_e = mul_op_e'(req_op);
  assign a_sgn    = op_a_signed(req_op_e);
  assign b_sgn    = op_b_signed(req_op_e);

  mul_sign_fix u_sign_fix (
    .prod   (prod_q),
    .neg    (neg_q),
    .hi_sel (op_q != MUL_OP_MUL),
    .word   (fix_word)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    err_d   = err_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op_e;
          neg_d   = (a_sgn & req_rs1[31]) ^ (b_sgn & req_rs2[31]);
          a_d     = mag(req_rs1, a_sgn);
          b_d     = mag(req_rs2, b_sgn);
          err_d   = 1'b0;
          state_d = LAUNCH;
`ifdef MUL_ZERO_SHORTCUT_EN
          if ((req_rs1 == 32'd0) || (req_rs2 == 32'd0)) begin
            data_d  = 32'd0;
            state_d = RESP;
          end
`endif
        end
      end
      LAUNCH: begin
        // Ready is not looked at here: it may still be high from the previous product.
        cnt_d   = 32'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mul_ready) begin
          prod_d  = {mul_hi, mul_lo};
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
          if ((MAX_WAIT != 0) && (cnt_d >= 32'(MAX_WAIT - 1))) begin
            err_d   = 1'b1;
            data_d  = 32'd0;
            state_d = RESP;
          end
        end
      end
      FIXUP: begin
        data_d  = fix_word;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= MUL_OP_MUL;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 32'd0;
      prod_q  <= 64'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      data_q  <= data_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mul_init   = (state_q == LAUNCH);
  assign resp_valid = (state_q == RESP);
  assign resp_err   = (state_q == RESP) & err_q;
  assign resp_data  = data_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;

endmodule

// File: tb/tb_mul_sign_ctrl.sv
// Scoreboard bench for mul_sign_ctrl with a behavioural multiplier core model.
module tb_mul_sign_ctrl;

  localparam int unsigned MaxWait = 40;
`ifdef MUL_ZERO_SHORTCUT_EN
  localparam bit Shortcut = 1'b1;
`else
  localparam bit Shortcut = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_init;
  logic        mul_ready = 1'b0;
  logic [31:0] mul_hi = '0;
  logic [31:0] mul_lo = '0;

  mul_sign_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_init   (mul_init),
    .mul_ready  (mul_ready),
    .mul_hi     (mul_hi),
    .mul_lo     (mul_lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int init_cnt = 0;
  int exp_inits = 0;
  int resp_cnt = 0;
  int init_cyc = 0;
  int resp_cyc = 0;
  int acc_cyc = 0;
  logic [32:0] sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: unsigned product after core_lat cycles; ready holds until the next init.
  int unsigned core_lat = 5;
  bit          core_hang = 1'b0;
  bit          busy = 1'b0;
  int unsigned cnt = 0;
  logic [63:0] pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      mul_ready <= 1'b0;
      busy      <= 1'b0;
    end else if (mul_init) begin
      mul_ready <= 1'b0;
      busy      <= 1'b1;
      cnt       <= core_lat;
      pend      <= {32'd0, mul_a} * {32'd0, mul_b};
    end else if (busy && !core_hang) begin
      if (cnt <= 1) begin
        mul_ready        <= 1'b1;
        {mul_hi, mul_lo} <= pend;
        busy             <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
  end

  function automatic logic [32:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sbv;
    logic [63:0] p;
    sa  = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'd0, a});
    sbv = (op == 2'b01) ? longint'($signed(b)) : longint'({32'd0, b});
    p   = 64'(sa * sbv);
    return {1'b0, (op == 2'b00) ? p[31:0] : p[63:32]};
  endfunction

  // Monitor
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (mul_init) begin
      init_cnt++;
      init_cyc = cyc;
    end
    if (resp_valid) begin
      logic [32:0] exp;
      resp_cnt++;
      resp_cyc = cyc;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL resp_pulse: resp_valid high two cycles running at cycle %0d", cyc);
      end
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got data=%h err=%b with nothing outstanding",
                 resp_data, resp_err);
      end else begin
        exp = sb_q.pop_front();
        if ({resp_err, resp_data} !== exp)
          begin
            errors++;
            $display("FAIL resp_data: got data=%h err=%b, want data=%h err=%b",
                     resp_data, resp_err, exp[31:0], exp[32]);
          end
      end
    end
    prev_valid = resp_valid;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit timeout);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_wait: got 0 after 300 cycles, want 1");
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    acc_cyc   = cyc;
    if (timeout) sb_q.push_back({1'b1, 32'd0});
    else         sb_q.push_back(ref_model(op, a, b));
    if (!(Shortcut && (a == 0 || b == 0))) exp_inits++;
    @(negedge clk);
    req_valid = 1'b0;
    req_rs1   = $urandom;
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || !req_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_wait: got %0d outstanding after 300 cycles, want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int base;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mul_init", {31'd0, mul_init}, 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);

    base = init_cnt;
    do_req(2'b00, 32'd7, 32'd6, 1'b0);
    wait_done();
    check("mul_init_once", init_cnt - base, 32'd1);
    repeat (4) @(negedge clk);
    check("resp_data_hold", resp_data, 32'h0000_002A);

    do_req(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_req(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0);
    do_req(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_req(2'b10, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done();

    // Back-to-back with random core latency; ready stays high between ops.
    for (int i = 0; i < 40; i++) begin
      core_lat = $urandom_range(1, 33);
      do_req(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);
    end
    wait_done();

    core_hang = 1'b1;
    do_req(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    wait_done();
    check("timeout_latency", resp_cyc - init_cyc, MaxWait);

    base = resp_cnt;
    do_req(2'b11, 32'h0000_0011, 32'h0000_0022, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rst_wait_idle", {31'd0, req_ready}, 32'd1);
    check("rst_wait_no_resp", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    core_hang = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_wait_discard", resp_cnt - base, 32'd0);

`ifdef MUL_ZERO_SHORTCUT_EN
    base = init_cnt;
    do_req(2'b00, 32'd0, 32'h0000_1234, 1'b0);
    wait_done();
    check("zero_latency", resp_cyc - acc_cyc, 32'd1);
    check("zero_no_init", init_cnt - base, 32'd0);
`endif

    do_req(2'b01, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_req(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done();
    check("init_total", init_cnt, exp_inits);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
